// File: rtl/comparator_status_queue.sv
// Queues comparator results and hands them one at a time to csr_registers.
// Define COMP_STATUS_OVERFLOW_EN to add the saturating overflow_count port.
module comparator_status_queue #(
  parameter int KEY_WIDTH = 4,
  parameter int DEPTH     = 8,
  parameter int PTR_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic                 in_collision,
  input  logic [1:0]           in_logical_core_id,
  input  logic [KEY_WIDTH-1:0] in_task_id,
  output logic                 in_ready,
  output logic                 comparator_status_write,
  output logic                 comparator_collision_detected,
  output logic [1:0]           comparator_logical_core_id,
  output logic [KEY_WIDTH-1:0] comparator_task_id,
  input  logic                 csr_status_ack,
  output logic [PTR_WIDTH:0]   queue_count
`ifdef COMP_STATUS_OVERFLOW_EN
  ,
  output logic [7:0]           overflow_count
`endif
);

  localparam int EW = KEY_WIDTH + 3;
  localparam logic [PTR_WIDTH:0] FULL = (PTR_WIDTH+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    RELEASE
  } state_t;

  state_t state, state_d;

  logic [EW-1:0]        mem [DEPTH];
  logic [PTR_WIDTH-1:0] rd_ptr, wr_ptr;
  logic [PTR_WIDTH:0]   count;
  logic                 push, pop;
  logic                 load, clear;

  assign pop         = (state == WRITE) && csr_status_ack;
  assign in_ready    = (count < FULL) || pop;
  assign push        = in_valid && in_ready;
  assign queue_count = count;

  always_comb begin
    state_d = state;
    load    = 1'b0;
    clear   = 1'b0;
    unique case (state)
      IDLE: begin
        if (count != '0) begin
          load    = 1'b1;
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (csr_status_ack) begin
          clear   = 1'b1;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (!csr_status_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  // Head entry is latched into the output registers, so a full-queue
  // push may overwrite its slot on the same edge it is popped.
  always_ff @(posedge clk) begin
    if (push && !reset)
      mem[wr_ptr] <= {in_collision, in_logical_core_id, in_task_id};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      comparator_status_write       <= 1'b0;
      comparator_collision_detected <= 1'b0;
      comparator_logical_core_id    <= '0;
      comparator_task_id            <= '0;
    end else if (load) begin
      comparator_status_write <= 1'b1;
      {comparator_collision_detected,
       comparator_logical_core_id,
       comparator_task_id} <= mem[rd_ptr];
    end else if (clear) begin
      comparator_status_write       <= 1'b0;
      comparator_collision_detected <= 1'b0;
      comparator_logical_core_id    <= '0;
      comparator_task_id            <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_WIDTH'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_WIDTH'(1);
      unique case ({push, pop})
        2'b10:   count <= count + (PTR_WIDTH+1)'(1);
        2'b01:   count <= count - (PTR_WIDTH+1)'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef COMP_STATUS_OVERFLOW_EN
  always_ff @(posedge clk) begin
    if (reset)
      overflow_count <= '0;
    else if (in_valid && !in_ready && overflow_count != 8'hFF)
      overflow_count <= overflow_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_comparator_status_queue.sv
// Directed bench for comparator_status_queue.
// Define COMP_STATUS_OVERFLOW_EN to also cover overflow_count.
module tb_comparator_status_queue;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_collision = 1'b0;
  logic [1:0] in_logical_core_id = '0;
  logic [3:0] in_task_id = '0;
  logic       in_ready;
  logic       comparator_status_write;
  logic       comparator_collision_detected;
  logic [1:0] comparator_logical_core_id;
  logic [3:0] comparator_task_id;
  logic       csr_status_ack = 1'b0;
  logic [3:0] queue_count;
`ifdef COMP_STATUS_OVERFLOW_EN
  logic [7:0] overflow_count;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  comparator_status_queue #(
    .KEY_WIDTH(4),
    .DEPTH(8),
    .PTR_WIDTH(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_collision(in_collision),
    .in_logical_core_id(in_logical_core_id),
    .in_task_id(in_task_id),
    .in_ready(in_ready),
    .comparator_status_write(comparator_status_write),
    .comparator_collision_detected(comparator_collision_detected),
    .comparator_logical_core_id(comparator_logical_core_id),
    .comparator_task_id(comparator_task_id),
    .csr_status_ack(csr_status_ack),
    .queue_count(queue_count)
`ifdef COMP_STATUS_OVERFLOW_EN
    ,
    .overflow_count(overflow_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic col, input logic [1:0] core,
                      input logic [3:0] tid);
    in_valid           = 1'b1;
    in_collision       = col;
    in_logical_core_id = core;
    in_task_id         = tid;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic deliver(input logic col, input logic [1:0] core,
                         input logic [3:0] tid, input bit chk_gap);
    int lows;
    lows = 0;
    while (!comparator_status_write && lows < 40) begin
      tick();
      lows++;
    end
    chk("deliver_seen", comparator_status_write, 1);
    chk("deliver_task", comparator_task_id, tid);
    chk("deliver_col", comparator_collision_detected, col);
    chk("deliver_core", comparator_logical_core_id, core);
    if (chk_gap) chk("deliver_gap_ge2", int'(lows >= 2), 1);
    csr_status_ack = 1'b1;
    tick();
    csr_status_ack = 1'b0;
    chk("after_ack_sw", comparator_status_write, 0);
    chk("after_ack_task", comparator_task_id, 0);
  endtask

  initial begin
    tick();
    tick();
    reset = 1'b0;
    chk("rst_sw", comparator_status_write, 0);
    chk("rst_count", queue_count, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_task", comparator_task_id, 0);
    chk("rst_col", comparator_collision_detected, 0);
`ifdef COMP_STATUS_OVERFLOW_EN
    chk("rst_ovf", overflow_count, 0);
`endif

    // single entry, one-cycle latency, ack two cycles after write
    push(1'b1, 2'd2, 4'd5);
    chk("t1_sw_push_edge", comparator_status_write, 0);
    chk("t1_count1", queue_count, 1);
    tick();
    chk("t1_sw_high", comparator_status_write, 1);
    chk("t1_col", comparator_collision_detected, 1);
    chk("t1_core", comparator_logical_core_id, 2);
    chk("t1_task", comparator_task_id, 5);
    tick();
    tick();
    csr_status_ack = 1'b1;
    tick();
    csr_status_ack = 1'b0;
    chk("t1_sw_low", comparator_status_write, 0);
    chk("t1_col_clr", comparator_collision_detected, 0);
    chk("t1_core_clr", comparator_logical_core_id, 0);
    chk("t1_task_clr", comparator_task_id, 0);
    chk("t1_count0", queue_count, 0);
    tick();

    // fill with tasks 0..7, ack held low
    for (int i = 0; i < 8; i++) begin
      chk("t2_ready", in_ready, 1);
      push(1'b0, 2'(i % 4), 4'(i));
    end
    chk("t2_count8", queue_count, 8);
    chk("t2_not_ready", in_ready, 0);
    chk("t2_head", comparator_task_id, 0);

    // drops while full
    for (int i = 0; i < 3; i++) begin
      in_valid   = 1'b1;
      in_task_id = 4'd15;
      tick();
    end
    in_valid = 1'b0;
    chk("t2_drop_count", queue_count, 8);
`ifdef COMP_STATUS_OVERFLOW_EN
    chk("ovf_3", overflow_count, 3);
`endif

    // push task 9 on the same edge as the ack pop while full
    in_valid           = 1'b1;
    in_collision       = 1'b1;
    in_logical_core_id = 2'd3;
    in_task_id         = 4'd9;
    csr_status_ack     = 1'b1;
    #1;
    chk("t3_ready_on_pop", in_ready, 1);
    tick();
    in_valid       = 1'b0;
    csr_status_ack = 1'b0;
    chk("t3_count8", queue_count, 8);
    chk("t3_sw_low", comparator_status_write, 0);
    for (int i = 1; i < 8; i++)
      deliver(1'b0, 2'(i % 4), 4'(i), 1'b1);
    deliver(1'b1, 2'd3, 4'd9, 1'b1);
    chk("t3_empty", queue_count, 0);
    tick();
    tick();

    // long ack: exactly one pop
    push(1'b0, 2'd1, 4'd3);
    push(1'b1, 2'd0, 4'd4);
    chk("t4_sw", comparator_status_write, 1);
    chk("t4_task3", comparator_task_id, 3);
    csr_status_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_sw_held_low", comparator_status_write, 0);
    end
    chk("t4_one_pop", queue_count, 1);
    csr_status_ack = 1'b0;
    tick();
    chk("t4_release_low", comparator_status_write, 0);
    tick();
    chk("t4_next_sw", comparator_status_write, 1);
    chk("t4_task4", comparator_task_id, 4);
    csr_status_ack = 1'b1;
    tick();
    csr_status_ack = 1'b0;
    chk("t4_empty", queue_count, 0);
    tick();

    // reset in WRITE with 3 entries queued
    push(1'b0, 2'd0, 4'd10);
    push(1'b0, 2'd0, 4'd11);
    push(1'b0, 2'd0, 4'd12);
    chk("t5_sw", comparator_status_write, 1);
    chk("t5_count3", queue_count, 3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_rst_sw", comparator_status_write, 0);
    chk("t5_rst_count", queue_count, 0);
    chk("t5_rst_ready", in_ready, 1);
    chk("t5_rst_task", comparator_task_id, 0);
    push(1'b0, 2'd1, 4'd6);
    deliver(1'b0, 2'd1, 4'd6, 1'b0);
    chk("t5_empty", queue_count, 0);
    tick();

`ifdef COMP_STATUS_OVERFLOW_EN
    for (int i = 0; i < 8; i++) push(1'b0, 2'd0, 4'(i));
    in_valid = 1'b1;
    for (int i = 0; i < 300; i++) tick();
    in_valid = 1'b0;
    chk("ovf_sat", overflow_count, 255);
    chk("ovf_count8", queue_count, 8);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
